// File: rtl/nes_clk_pkg.sv
// -----------------------------------------------------------------------------
// nes_clk_pkg
// Shared definitions for the NES clock sequencer:
//   clkseq_state_t : sequencer states (WAIT_LOCK, HOLD, RUN, LOST)
//   NES_CYCLE_LEN  : default phase counter modulus (one CPU cycle)
//   NES_PPU_DIV    : default PPU enable period in phases
// -----------------------------------------------------------------------------
package nes_clk_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2,
      LOST      = 2'd3
   } clkseq_state_t;

   localparam int NES_CYCLE_LEN = 12;
   localparam int NES_PPU_DIV   = 4;

endpackage

// File: rtl/nes_clk_sequencer_lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// Two-flop synchronizer bringing the asynchronous PLL lock into clk.
// Both flops reset to 0 so a core reset always re-qualifies lock.
// Ports:
//   clk     : clock
//   reset   : synchronous active-high reset
//   i_async : asynchronous input
//   o_sync  : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module lock_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/nes_clk_sequencer.sv
// -----------------------------------------------------------------------------
// nes_clk_sequencer
// Turns the NES PLL clock and lock indication into a sequenced time base:
// holds the core in reset until lock has been stable for RESET_HOLD cycles,
// then generates CPU/PPU single-cycle clock enables from one phase counter.
// A sustained lock loss (LOSS_FILTER cycles) drops back into reset.
//
// Optional feature macro: NES_CLKSEQ_LOSS_COUNT_EN adds the loss_cnt port
// and its saturating lock-loss event counter.
//
// Ports:
//   clk       : PLL output clock
//   reset     : synchronous active-high reset
//   pll_lock  : asynchronous lock from the PLL
//   pause     : freezes phase and suppresses enables while running
//   nes_reset : active-high core reset
//   cpu_ce    : CPU clock enable (1 of every CYCLE_LEN cycles)
//   ppu_ce    : PPU clock enable (1 of every PPU_DIV cycles)
//   phase     : current phase, 0..CYCLE_LEN-1
//   running   : high while the sequencer is running
//   loss_cnt  : lock-loss events, saturating at 255 (macro only)
// -----------------------------------------------------------------------------
module nes_clk_sequencer
   import nes_clk_pkg::*;
#(
   parameter int RESET_HOLD  = 1024,
   parameter int LOSS_FILTER = 4,
   parameter int CYCLE_LEN   = NES_CYCLE_LEN,
   parameter int PPU_DIV     = NES_PPU_DIV
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pll_lock,
   input  logic                         pause,
   output logic                         nes_reset,
   output logic                         cpu_ce,
   output logic                         ppu_ce,
   output logic [$clog2(CYCLE_LEN)-1:0] phase,
   output logic                         running
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
   ,
   output logic [7:0]                   loss_cnt
`endif
);

   localparam int PHASE_W = $clog2(CYCLE_LEN);
   localparam int HOLD_W  = $clog2(RESET_HOLD + 1);
   localparam int FILT_W  = $clog2(LOSS_FILTER + 1);

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CYCLE_LEN - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
   localparam logic [FILT_W-1:0]  FILT_LIMIT = FILT_W'(LOSS_FILTER);

   logic w_lock_s;

   clkseq_state_t       r_state;
   clkseq_state_t       w_state_next;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [HOLD_W-1:0]   w_hold_cnt_next;
   logic [FILT_W-1:0]   r_filt_cnt;
   logic [FILT_W-1:0]   w_filt_cnt_next;
   logic                r_nes_reset;
   logic                w_nes_reset_next;
   logic                r_cpu_ce;
   logic                w_cpu_ce_next;
   logic                r_ppu_ce;
   logic                w_ppu_ce_next;
   logic [PHASE_W-1:0]  r_phase;
   logic [PHASE_W-1:0]  w_phase_next;
   logic                r_running;
   logic                w_running_next;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
   logic [7:0]          r_loss_cnt;
   logic [7:0]          w_loss_cnt_next;
`endif

   logic [PHASE_W-1:0]  w_phase_inc;
   logic [FILT_W-1:0]   w_filt_inc;
   logic                w_hold_done;

   lock_sync u_lock_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (pll_lock),
      .o_sync  (w_lock_s)
   );

   // Enables are decoded from the phase about to be loaded, so that the
   // registered enable is coincident with the registered phase value.
   assign w_phase_inc = (r_phase == PHASE_LAST) ? '0 : r_phase + PHASE_W'(1);
   // Consecutive low-lock run length; any high sample restarts it.
   assign w_filt_inc  = w_lock_s ? '0 : r_filt_cnt + FILT_W'(1);
   assign w_hold_done = (r_hold_cnt == HOLD_LAST);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= WAIT_LOCK;
         r_hold_cnt  <= '0;
         r_filt_cnt  <= '0;
         r_nes_reset <= 1'b1;
         r_cpu_ce    <= 1'b0;
         r_ppu_ce    <= 1'b0;
         r_phase     <= '0;
         r_running   <= 1'b0;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
         r_loss_cnt  <= '0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_hold_cnt  <= w_hold_cnt_next;
         r_filt_cnt  <= w_filt_cnt_next;
         r_nes_reset <= w_nes_reset_next;
         r_cpu_ce    <= w_cpu_ce_next;
         r_ppu_ce    <= w_ppu_ce_next;
         r_phase     <= w_phase_next;
         r_running   <= w_running_next;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
         r_loss_cnt  <= w_loss_cnt_next;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WAIT_LOCK: if (w_lock_s) w_state_next = HOLD;
         HOLD: begin
            // Any low sample restarts qualification; no filtering here.
            if (!w_lock_s)        w_state_next = WAIT_LOCK;
            else if (w_hold_done) w_state_next = RUN;
         end
         RUN:  if (w_filt_inc == FILT_LIMIT) w_state_next = LOST;
         LOST: w_state_next = WAIT_LOCK;
         default: w_state_next = WAIT_LOCK;
      endcase
   end

   // Next values of counters and registered outputs
   always_comb begin
      w_hold_cnt_next  = r_hold_cnt;
      w_filt_cnt_next  = r_filt_cnt;
      w_nes_reset_next = r_nes_reset;
      w_cpu_ce_next    = r_cpu_ce;
      w_ppu_ce_next    = r_ppu_ce;
      w_phase_next     = r_phase;
      w_running_next   = r_running;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
      w_loss_cnt_next  = r_loss_cnt;
`endif
      case (r_state)
         WAIT_LOCK: begin
            w_hold_cnt_next  = '0;
            w_filt_cnt_next  = '0;
            w_nes_reset_next = 1'b1;
            w_cpu_ce_next    = 1'b0;
            w_ppu_ce_next    = 1'b0;
            w_running_next   = 1'b0;
         end
         HOLD: begin
            w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
            if (w_lock_s && w_hold_done) begin
               // Entry pulse on both enables fires even when paused.
               w_nes_reset_next = 1'b0;
               w_phase_next     = '0;
               w_cpu_ce_next    = 1'b1;
               w_ppu_ce_next    = 1'b1;
               w_running_next   = 1'b1;
               w_filt_cnt_next  = '0;
            end
         end
         RUN: begin
            w_filt_cnt_next = w_filt_inc;
            if (pause) begin
               w_cpu_ce_next = 1'b0;
               w_ppu_ce_next = 1'b0;
            end else begin
               w_phase_next  = w_phase_inc;
               w_cpu_ce_next = (w_phase_inc == '0);
               w_ppu_ce_next = ((32'(w_phase_inc) % 32'(PPU_DIV)) == 32'd0);
            end
         end
         LOST: begin
            w_hold_cnt_next  = '0;
            w_filt_cnt_next  = '0;
            w_nes_reset_next = 1'b1;
            w_cpu_ce_next    = 1'b0;
            w_ppu_ce_next    = 1'b0;
            w_running_next   = 1'b0;
            w_phase_next     = '0;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
            if (r_loss_cnt != 8'hFF) w_loss_cnt_next = r_loss_cnt + 8'd1;
`endif
         end
         default: ;
      endcase
   end

   assign nes_reset = r_nes_reset;
   assign cpu_ce    = r_cpu_ce;
   assign ppu_ce    = r_ppu_ce;
   assign phase     = r_phase;
   assign running   = r_running;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
   assign loss_cnt  = r_loss_cnt;
`endif

endmodule

// File: tb/tb_nes_clk_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nes_clk_sequencer
// Directed bench for nes_clk_sequencer with RESET_HOLD=16, LOSS_FILTER=4,
// CYCLE_LEN=12, PPU_DIV=4. Edge numbering: "edge 0" is the clock edge just
// before pll_lock is driven high; outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_nes_clk_sequencer;

   localparam int RH = 16;
   localparam int LF = 4;
   localparam int CL = 12;
   localparam int PD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       pause;
   logic       nes_reset;
   logic       cpu_ce;
   logic       ppu_ce;
   logic [3:0] phase;
   logic       running;
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
   logic [7:0] loss_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int exp_phase = 0;

   nes_clk_sequencer #(
      .RESET_HOLD  (RH),
      .LOSS_FILTER (LF),
      .CYCLE_LEN   (CL),
      .PPU_DIV     (PD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .pause     (pause),
      .nes_reset (nes_reset),
      .cpu_ce    (cpu_ce),
      .ppu_ce    (ppu_ce),
      .phase     (phase),
      .running   (running)
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
      ,
      .loss_cnt  (loss_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pll_lock = 1'b0; pause = 1'b0;
      tick(); tick();
      n_vec++;
      if ({nes_reset, cpu_ce, ppu_ce, running} !== 4'b1000) begin
         $display("FAIL reset_ctl: got nes_reset/cpu/ppu/run=%b want 1000",
                  {nes_reset, cpu_ce, ppu_ce, running});
         n_err++;
      end
      n_vec++;
      if (phase !== 4'd0) begin
         $display("FAIL reset_phase: got %0d want 0", phase);
         n_err++;
      end
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
      n_vec++;
      if (loss_cnt !== 8'd0) begin
         $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt);
         n_err++;
      end
`endif
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (nes_reset !== 1'b1 || running !== 1'b0) begin
            $display("FAIL wait_lock_idle: got nes_reset=%b running=%b want 1/0",
                     nes_reset, running);
            n_err++;
         end
      end
      $display("test_reset done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   // Called just after "edge 0"; nes_reset must fall exactly at edge 3+RH.
   task automatic test_lock_hold();
      pll_lock = 1'b1;
      for (int k = 1; k <= 3 + RH; k++) begin
         tick();
         n_vec++;
         if (nes_reset !== ((k < 3 + RH) ? 1'b1 : 1'b0)) begin
            $display("FAIL hold_nes_reset edge %0d: got %b want %b",
                     k, nes_reset, (k < 3 + RH));
            n_err++;
         end
      end
      n_vec++;
      if ({cpu_ce, ppu_ce, running} !== 3'b111 || phase !== 4'd0) begin
         $display("FAIL run_entry: got cpu/ppu/run=%b phase=%0d want 111 phase=0",
                  {cpu_ce, ppu_ce, running}, phase);
         n_err++;
      end
      exp_phase = 0;
      $display("test_lock_hold done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   task automatic test_run();
      int cpu_pulses = 0;
      int ppu_pulses = 0;
      for (int i = 1; i <= 48; i++) begin
         tick();
         exp_phase = (exp_phase + 1) % CL;
         if (cpu_ce === 1'b1) cpu_pulses++;
         if (ppu_ce === 1'b1) ppu_pulses++;
         n_vec++;
         if (phase !== 4'(exp_phase)) begin
            $display("FAIL run_phase cycle %0d: got %0d want %0d", i, phase, exp_phase);
            n_err++;
         end
         n_vec++;
         if (cpu_ce !== (exp_phase == 0) || ppu_ce !== (exp_phase % PD == 0)) begin
            $display("FAIL run_enables phase %0d: got cpu=%b ppu=%b want %b %b",
                     exp_phase, cpu_ce, ppu_ce, (exp_phase == 0), (exp_phase % PD == 0));
            n_err++;
         end
      end
      n_vec++;
      if (cpu_pulses != 4) begin
         $display("FAIL run_cpu_count: got %0d want 4", cpu_pulses);
         n_err++;
      end
      n_vec++;
      if (ppu_pulses != 12) begin
         $display("FAIL run_ppu_count: got %0d want 12", ppu_pulses);
         n_err++;
      end
      $display("test_run done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   task automatic test_pause();
      for (int i = 0; i < 3; i++) tick();
      n_vec++;
      if (phase !== 4'd3) begin
         $display("FAIL pause_setup_phase: got %0d want 3", phase);
         n_err++;
      end
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if (phase !== 4'd3 || cpu_ce !== 1'b0 || ppu_ce !== 1'b0) begin
            $display("FAIL pause_hold: got phase=%0d cpu=%b ppu=%b want 3 0 0",
                     phase, cpu_ce, ppu_ce);
            n_err++;
         end
      end
      pause = 1'b0;
      tick();
      n_vec++;
      if (phase !== 4'd4 || ppu_ce !== 1'b1 || cpu_ce !== 1'b0) begin
         $display("FAIL pause_release: got phase=%0d cpu=%b ppu=%b want 4 0 1",
                  phase, cpu_ce, ppu_ce);
         n_err++;
      end
      exp_phase = 4;
      $display("test_pause done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   task automatic test_glitch();
      pll_lock = 1'b0;
      tick(); tick();
      pll_lock = 1'b1;
      exp_phase = (exp_phase + 2) % CL;
      for (int i = 0; i < 10; i++) begin
         tick();
         exp_phase = (exp_phase + 1) % CL;
         n_vec++;
         if (phase !== 4'(exp_phase) || running !== 1'b1 || nes_reset !== 1'b0) begin
            $display("FAIL glitch_run: got phase=%0d run=%b nes_reset=%b want %0d 1 0",
                     phase, running, nes_reset, exp_phase);
            n_err++;
         end
      end
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
      n_vec++;
      if (loss_cnt !== 8'd0) begin
         $display("FAIL glitch_loss_cnt: got %0d want 0", loss_cnt);
         n_err++;
      end
`endif
      $display("test_glitch done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   // Lock dropped after edge E: lock_s low from S=E+2, nes_reset at S+LF+1.
   task automatic test_loss(input int exp_loss);
      pll_lock = 1'b0;
      for (int k = 1; k <= 3 + LF; k++) begin
         tick();
         n_vec++;
         if (k < 3 + LF) begin
            if (nes_reset !== 1'b0 || running !== 1'b1) begin
               $display("FAIL loss_filtering edge %0d: got nes_reset=%b run=%b want 0 1",
                        k, nes_reset, running);
               n_err++;
            end
         end else begin
            if ({nes_reset, cpu_ce, ppu_ce, running} !== 4'b1000 || phase !== 4'd0) begin
               $display("FAIL loss_reassert: got ctl=%b phase=%0d want 1000 phase=0",
                        {nes_reset, cpu_ce, ppu_ce, running}, phase);
               n_err++;
            end
         end
      end
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
      n_vec++;
      if (loss_cnt !== 8'(exp_loss)) begin
         $display("FAIL loss_cnt: got %0d want %0d", loss_cnt, exp_loss);
         n_err++;
      end
`else
      if (exp_loss < 0) $display("unexpected loss index");
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (nes_reset !== 1'b1 || running !== 1'b0) begin
            $display("FAIL loss_wait_lock: got nes_reset=%b run=%b want 1 0",
                     nes_reset, running);
            n_err++;
         end
      end
      $display("test_loss done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   task automatic test_reset_in_hold();
      pll_lock = 1'b1;
      for (int k = 1; k <= 13; k++) tick();
      n_vec++;
      if (nes_reset !== 1'b1) begin
         $display("FAIL hold_pre_reset: got nes_reset=%b want 1", nes_reset);
         n_err++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if ({nes_reset, cpu_ce, ppu_ce, running} !== 4'b1000 || phase !== 4'd0) begin
         $display("FAIL hold_reset_values: got ctl=%b phase=%0d want 1000 phase=0",
                  {nes_reset, cpu_ce, ppu_ce, running}, phase);
         n_err++;
      end
`ifdef NES_CLKSEQ_LOSS_COUNT_EN
      n_vec++;
      if (loss_cnt !== 8'd0) begin
         $display("FAIL hold_reset_loss_cnt: got %0d want 0", loss_cnt);
         n_err++;
      end
`endif
      // Reset at edge 14 restarts qualification: release at 14+3+RH.
      for (int k = 15; k <= 14 + 3 + RH; k++) begin
         tick();
         n_vec++;
         if (nes_reset !== ((k < 14 + 3 + RH) ? 1'b1 : 1'b0)) begin
            $display("FAIL hold_restart edge %0d: got nes_reset=%b want %b",
                     k, nes_reset, (k < 14 + 3 + RH));
            n_err++;
         end
      end
      n_vec++;
      if ({cpu_ce, ppu_ce, running} !== 3'b111) begin
         $display("FAIL hold_restart_entry: got cpu/ppu/run=%b want 111",
                  {cpu_ce, ppu_ce, running});
         n_err++;
      end
      $display("test_reset_in_hold done: %0d vectors, %0d miscompares so far", n_vec, n_err);
   endtask

   initial begin
      test_reset();
      test_lock_hold();
      test_run();
      test_pause();
      test_glitch();
      test_loss(1);
      test_lock_hold();
      test_loss(2);
      test_reset_in_hold();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nes_clk_sequencer.md
# nes_clk_sequencer

Consumes the lock output of the NES system PLL and turns its raw clock into a sequenced, phase-aligned NES time base. Holds the core in reset until lock has been stable for a programmable time. Then produces the CPU and PPU single-cycle clock enables from one shared phase counter. Sits directly after the PLL in the top level and feeds reset and enables to every NES core block.

## Interface
- `RESET_HOLD`, default 1024: clk cycles of stable lock required before `nes_reset` deasserts.
- `LOSS_FILTER`, default 4: consecutive cycles of synchronized lock low that count as lock loss.
- `CYCLE_LEN`, default 12: phase counter modulus, one CPU cycle.
- `PPU_DIV`, default 4: PPU enable period in phases. `CYCLE_LEN` must be a multiple of `PPU_DIV`.
- `clk` in 1: PLL output clock; the only clock in the block.
- `reset` in 1: synchronous, active-high reset.
- `pll_lock` in 1: asynchronous lock from the PLL.
- `pause` in 1: freezes the phase counter and suppresses enables.
- `nes_reset` out 1: active-high core reset.
- `cpu_ce` out 1: CPU clock enable.
- `ppu_ce` out 1: PPU clock enable.
- `phase` out $clog2(CYCLE_LEN): current phase.
- `running` out 1: high in state RUN.
- `loss_cnt` out 8: lock-loss event count, present only with the macro enabled.

## Operation
- `pll_lock` passes through a 2-FF synchronizer; the synchronized signal is `lock_s`.
- All outputs are registered.
- Reset values:
  - state WAIT_LOCK, `nes_reset`=1, `cpu_ce`=0, `ppu_ce`=0, `phase`=0, `running`=0, `loss_cnt`=0.
  - Hold and filter counters are 0.
- WAIT_LOCK:
  - `nes_reset`=1, enables 0.
  - Moves to HOLD when `lock_s`=1, clearing the hold counter.
- HOLD:
  - Hold counter increments each cycle.
  - `lock_s`=0 in any cycle returns to WAIT_LOCK. No filtering applies in HOLD.
  - When the counter reaches `RESET_HOLD`-1, moves to RUN. In the same edge: `nes_reset`<=0, `phase`<=0, `cpu_ce`<=1, `ppu_ce`<=1, `running`<=1.
- RUN:
  - `pause`=0: `phase` advances, wrapping from `CYCLE_LEN`-1 to 0. `cpu_ce`<=(next phase==0), `ppu_ce`<=(next phase mod `PPU_DIV`==0).
  - `pause`=1: `phase` holds, both enables <=0.
  - Filter counter counts consecutive `lock_s`=0 cycles and clears on any `lock_s`=1.
  - On reaching `LOSS_FILTER`, moves to LOST.
- LOST:
  - Exactly one cycle. `nes_reset`<=1, enables <=0, `running`<=0, `phase`<=0.
  - Next state is WAIT_LOCK.
  - `loss_cnt` increments, saturating at 255.
- `reset` mid-operation forces all reset values on the next edge, regardless of state.
- If `pause` is high on the RUN entry edge, the entry still produces one pulse on each enable. Pause takes effect from the following cycle.

## Timing
- `pll_lock` rising is sampled at edge 0. Then `lock_s`=1 after edge 2, state is HOLD after edge 3, and `nes_reset` falls at edge 3+`RESET_HOLD`.
- In RUN with no pause:
  - `cpu_ce` is high 1 cycle in every `CYCLE_LEN`.
  - `ppu_ce` is high 1 cycle in every `PPU_DIV`.
  - Both are coincident when `phase`=0.
- A lock glitch shorter than `LOSS_FILTER` cycles at `lock_s` has no effect in RUN.
- `nes_reset` reasserts at edge S+`LOSS_FILTER`+1, where S is the first edge at which `lock_s` is 0.

## Configuration
- `NES_CLKSEQ_LOSS_COUNT_EN` defined: the `loss_cnt` port and its saturating counter are present.
- Undefined: the port and its logic are removed. The LOST state still exists and behaves identically otherwise.

## Structure
- Shared package `nes_clk_pkg` holds:
  - the state enum `clkseq_state_t` (WAIT_LOCK, HOLD, RUN, LOST);
  - the default constants `NES_CYCLE_LEN`=12 and `NES_PPU_DIV`=4.
- One sub-module, `lock_sync`: a 2-FF synchronizer with reset value 0.

## Test plan
- `RESET_HOLD`=16; `pll_lock` rises at edge 0 -> `nes_reset` falls at edge 19; `cpu_ce` and `ppu_ce` are both 1 at edge 19.
- RUN for 48 cycles with no pause -> exactly 4 `cpu_ce` pulses and 12 `ppu_ce` pulses; `phase` sequence 0..11 repeating.
- `pause` high for 5 cycles at `phase`=3 -> `phase` stays 3, enables stay 0; `ppu_ce` is next asserted at `phase`=4 after release.
- `pll_lock` low for 2 cycles in RUN with `LOSS_FILTER`=4 -> no state change, `loss_cnt`=0.
- `pll_lock` low persistently in RUN -> `nes_reset`=1 at S+5; `loss_cnt`=1; WAIT_LOCK; on relock, the full hold sequence repeats.
- `reset` pulsed while in HOLD at count 10 -> all outputs return to reset values on the next edge, and the hold restarts from 0.
